uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin scheduler that shares the single word-level UART transmit path between `N_REQ` on-chip result producers. It sits directly in front of the `uart` block's tx side. It picks one requester and latches that requester's word vector onto `tx_nums`. It then pulses `send_data`, waits for the UART to report `tx_ready` again, and acknowledges the requester. A watchdog aborts any transfer the UART never completes.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `N_TX_NUMS`, 1: words per transfer; must equal the `uart` instance's `n_tx_nums`.
- `TIMEOUT_CYCLES`, 65535: maximum cycles in WAIT before abort (≥ 4).
- `clk`  in  1  system clock, all logic on rising edge.
- `n_reset`  in  1  reset; one clock domain, asynchronous, active-low.
- `req`  in  N_REQ  per-requester transfer request; level, held until `done` or `gnt` drop.
- `req_data`  in  N_REQ × N_TX_NUMS × `num`  per-requester payload; sampled only in the grant cycle.
- `gnt`  out  N_REQ  one-hot; identifies the requester being served from ISSUE through WAIT.
- `done`  out  N_REQ  one-cycle pulse to the served requester on successful completion.
- `busy`  out  1  high in ISSUE and WAIT.
- `timeout_err`  out  1  sticky; set on watchdog abort.
- `err_clr`  in  1  clears `timeout_err`.
- `send_data`  out  1  one-cycle start strobe to `uart`.
- `tx_nums`  out  N_TX_NUMS × `num`  payload to `uart`; registered, stable from ISSUE through WAIT.
- `tx_ready`  in  1  from `uart`; high when the UART is idle and can accept a vector.

## Operation
- Reset values: `send_data`=0, `gnt`=0, `done`=0, `busy`=0, `timeout_err`=0, `tx_nums`=all 0, state=IDLE, last-grant pointer=`N_REQ-1` (so req 0 has top priority first).
- IDLE: when `|req` and `tx_ready` are both high, the scheduler does the following:
  - selects a winner by round-robin, searching from pointer+1 upward with wrap;
  - registers `gnt`=onehot(winner) and `tx_nums`=`req_data[winner]`;
  - sets `send_data`=1 and the pointer to the winner;
  - moves to ISSUE.
- If `|req` is high but `tx_ready` is low, the scheduler stays in IDLE and issues no grant.
- ISSUE (exactly 1 cycle): `send_data`=1 and the UART latches `tx_nums` at the end of this cycle. Next state is WAIT, with `send_data`=0 and the watchdog counter cleared to 0.
- WAIT: the counter increments every cycle.
  - `tx_ready`=1 → `done[winner]` pulses for 1 cycle, `gnt`=0, state returns to IDLE.
  - Counter reaches `TIMEOUT_CYCLES-1` with `tx_ready` still 0 → abort: `timeout_err`=1, `gnt`=0, no `done`, state returns to IDLE.
  - After an abort the pointer is kept, so the same requester is not retried ahead of others.
- Dropping `req` during ISSUE or WAIT does not abort the transfer; `done` is still pulsed.
- `req_data` changes after the grant cycle have no effect.
- `err_clr` and a new timeout in the same cycle: set wins.
- `n_reset` asserted mid-transfer: all outputs return to their reset values immediately. The UART may still finish its current vector; no `done` is issued for it.

## Timing
- Requester `req` high in cycle c with `tx_ready`=1 and state IDLE → `gnt` and `send_data` high in c+1.
- The UART's `tx_ready` is low while it is transmitting. The scheduler enters WAIT in c+2.
- If `tx_ready` is first seen high in WAIT at cycle d, then `done` is high in d+1 and IDLE resumes in d+1.
  - The earliest next grant is then in d+2.
- Minimum scheduler overhead is 3 cycles per transfer beyond the UART time.
- `send_data` is never high on two consecutive cycles and is never issued while `tx_ready`=0.
- `gnt` changes only on the IDLE→ISSUE edge or the WAIT→IDLE edge.

## Structure
- Shared package `uart_pkg`:
  - the `num` typedef (signed 16-bit);
  - the state enum {IDLE, ISSUE, WAIT};
  - the default `TIMEOUT_CYCLES` constant.
- One sub-module, `rr_arbiter`: combinational round-robin pick from `req` and the pointer; outputs a one-hot grant and the winner index.
- The counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Single requester: req0=1 with `req_data[0]`=16'sh1234 and `tx_ready`=1 → `send_data` for one cycle with `tx_nums[0]`=16'sh1234 and `gnt`=4'b0001. Model `tx_ready` low for 40 cycles → `done`=4'b0001 exactly once.
- All four requesters held high over 8 transfers → grant order 0,1,2,3,0,1,2,3. `done` count equals 2 per requester.
- `tx_ready` held low in IDLE with req2=1 → no `send_data` or `gnt` for 100 cycles. Raise `tx_ready` → grant arrives one cycle later.
- `TIMEOUT_CYCLES`=16 and the UART model never re-asserts `tx_ready` → `timeout_err`=1 at cycle 16 of WAIT with no `done`. Pulse `err_clr` → `timeout_err`=0.
- Change `req_data[1]` and drop req1 during WAIT → the UART receives the original value and `done[1]` still pulses.
- Assert `n_reset` low mid-WAIT → all outputs reset asynchronously. After release, req3 alone is granted and completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart tx scheduler
package uart_pkg;

    // One UART word.
    typedef logic signed [15:0] num;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Default watchdog limit, in cycles spent in WAIT.
    localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester and uart-side signal bundle for uart_tx_sched
//
// Ports (slave = scheduler view):
//   req, req_data, err_clr, tx_ready      : into the scheduler
//   gnt, done, busy, timeout_err,
//   send_data, tx_nums                    : out of the scheduler
interface uart_tx_sched_if import uart_pkg::*; #(
    parameter int N_REQ     = 4,
    parameter int N_TX_NUMS = 1
) ();
    logic [N_REQ-1:0]                  req;
    num   [N_REQ-1:0][N_TX_NUMS-1:0]   req_data;
    logic [N_REQ-1:0]                  gnt;
    logic [N_REQ-1:0]                  done;
    logic                              busy;
    logic                              timeout_err;
    logic                              err_clr;
    logic                              send_data;
    num   [N_TX_NUMS-1:0]              tx_nums;
    logic                              tx_ready;

    modport slave (
        input  req, req_data, err_clr, tx_ready,
        output gnt, done, busy, timeout_err, send_data, tx_nums
    );

    modport master (
        output req, req_data, err_clr, tx_ready,
        input  gnt, done, busy, timeout_err, send_data, tx_nums
    );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rtl/uart_tx_sched_rr_arbiter.sv - combinational round-robin pick
//
// Ports:
//   req  in  N_REQ   request vector
//   ptr  in  IDX_W   index of the last granted requester
//   gnt  out N_REQ   one-hot winner (all zero when no request)
//   idx  out IDX_W   winner index
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);
    logic found;
    int   k;

    // Search starts just after the last winner and wraps, so the last
    // winner itself is examined last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(ptr) + i) % N_REQ;
            if (!found && req[IDX_W'(k)]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
        gnt[idx] = found;
    end
endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart tx path
//
// Ports:
//   clk      in   system clock
//   n_reset  in   asynchronous active-low reset
//   bus      slave view of uart_tx_sched_if (requesters + uart tx side)
module uart_tx_sched import uart_pkg::*; #(
    parameter int N_REQ          = 4,
    parameter int N_TX_NUMS      = 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            n_reset,
    uart_tx_sched_if.slave  bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_d;
    logic [IDX_W-1:0]       ptr, ptr_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [N_REQ-1:0]       gnt, gnt_d;
    logic [N_REQ-1:0]       done, done_d;
    logic                   send, send_d;
    logic                   err, err_d;
    num [N_TX_NUMS-1:0]     nums, nums_d;

    logic [N_REQ-1:0]       arb_gnt;
    logic [IDX_W-1:0]       arb_idx;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            ptr   <= IDX_W'(N_REQ - 1);
            cnt   <= '0;
            gnt   <= '0;
            done  <= '0;
            send  <= 1'b0;
            err   <= 1'b0;
            nums  <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
            gnt   <= gnt_d;
            done  <= done_d;
            send  <= send_d;
            err   <= err_d;
            nums  <= nums_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        gnt_d   = gnt;
        done_d  = '0;
        send_d  = 1'b0;
        nums_d  = nums;
        // Clear first; a timeout below overrides it in the same cycle.
        err_d   = err & ~bus.err_clr;
        unique case (state)
            IDLE: begin
                if (|bus.req && bus.tx_ready) begin
                    state_d = ISSUE;
                    gnt_d   = arb_gnt;
                    nums_d  = bus.req_data[arb_idx];
                    send_d  = 1'b1;
                    ptr_d   = arb_idx;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.tx_ready) begin
                    done_d  = gnt;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt == CNT_LAST) begin
                    // Pointer is left on the aborted requester so it goes
                    // to the back of the round-robin order.
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt         = gnt;
    assign bus.done        = done;
    assign bus.send_data   = send;
    assign bus.timeout_err = err;
    assign bus.tx_nums     = nums;
    assign bus.busy        = (state != IDLE);
endmodule
